rtype_issue_ctrl: RTL and testbench
===================================

// Module: rtype_issue_ctrl
// PURPOSE
// Issue controller for the register-file/ALU datapath. It accepts one MIPS R-type instruction at a time over a valid/ready handshake.
// - Sequences the register-file reads, ALU operation and write-back with a multi-cycle FSM.
// - Drives RR1/RR2/WR/WE of RegisterFile, Op/ShiftCount of OurALU and the write-back mux select.
// PARAMETERS
// EXEC_CYCLES  1  ALU settle cycles spent in EXEC (range 1..15)
// PROTECT_R0   1  1: writes with rd==0 are suppressed (no WE); 0: allowed
// PORTS
// Clk          in   1   clock, all state updates on posedge
// Rst          in   1   asynchronous, active-high reset
// instr        in   32  R-type instruction word {op[31:26],rs,rt,rd,shamt,funct[5:0]}
// instr_valid  in   1   instr is valid this cycle
// instr_ready  out  1   controller can accept; transfer when valid&&ready
// RR1          out  5   register file read address 1 (ALU A)
// RR2          out  5   register file read address 2 (ALU B)
// WR           out  5   register file write address
// WE           out  1   register file write enable, one-cycle pulse
// AluOp        out  4   ALU op code
// ShiftCount   out  5   ALU shift amount
// WbSel        out  1   write-back mux select, 1 = ALU result
// done         out  1   one-cycle pulse when instruction retires (legal or not)
// illegal      out  1   one-cycle pulse with done for an unsupported instruction
// retired      out  16  count of legal retired instructions, wraps 0xFFFF->0
// BEHAVIOUR
// - Reset (async, Rst=1): state IDLE, instr_ready=1, all other outputs 0, retired=0, latched instr=0.
// - FSM states: IDLE -> READ -> EXEC -> WRITE -> IDLE.
//   IDLE: instr_ready=1. On valid&&ready, latch instr and go to READ. The accept cycle is cycle 0.
//   READ (cycle 1): drive RR1/RR2/AluOp/ShiftCount/WR/WbSel=1. instr_ready=0.
//   EXEC: hold all datapath outputs for EXEC_CYCLES cycles, using an internal down-counter, then go to WRITE.
//   WRITE: WE=1 for exactly this cycle unless suppressed. done=1. Next state IDLE.
// - Latency: with EXEC_CYCLES=1, WE and done are high in cycle 3 and instr_ready returns in cycle 4. The minimum issue interval is 4 cycles.
// - Datapath outputs (RR1/RR2/AluOp/ShiftCount/WR/WbSel) hold their values from READ through WRITE.
//   - They are reset to 0 in IDLE only by Rst. Otherwise they keep their last values in IDLE.
// - Decode (op must be 6'h00, else illegal):
//   funct 0x20 add -> 4'b0010; 0x22 sub -> 4'b0110; 0x24 and -> 4'b0000; 0x25 or -> 4'b0001
//   funct 0x27 nor -> 4'b1100; 0x2A slt -> 4'b0111
//   funct 0x00 sll -> 4'b1110; 0x02 srl -> 4'b1101; 0x03 sra -> 4'b1111
// - Non-shift ops: RR1=rs, RR2=rt, ShiftCount=0.
// - Shift ops: RR1=rt (the ALU shifts A), RR2=rt, ShiftCount=shamt. rs is ignored.
// - Illegal instruction:
//   - The FSM still walks READ/EXEC/WRITE.
//   - WE stays 0 and AluOp=4'b0000.
//   - done=1 and illegal=1 in WRITE.
//   - retired is not incremented.
// - rd==0 with PROTECT_R0=1: WE is suppressed, done=1, illegal=0, and retired is incremented.
// - retired increments in the WRITE cycle of every legal instruction.
// - instr_valid while busy: ignored. The upstream stage holds instr until it sees ready.
// - Rst asserted mid-operation: return immediately to IDLE with reset values.
//   - No WE or done pulse is produced for the aborted instruction.
// - WE is never high outside WRITE. done and WE are never high for more than one cycle per instruction.
// TESTING
// 1. Rst pulse mid-EXEC of an add -> instr_ready=1 next cycle, WE never asserted, retired=0.
// 2. add $3,$1,$2 (0x00221820), EXEC_CYCLES=1:
//    - accept at cycle 0; cycle 1: RR1=1, RR2=2, AluOp=0010.
//    - cycle 3: WE=1, WR=3, done=1; cycle 4: instr_ready=1; retired=1.
// 3. sra $5,$4,2 (0x00042883) -> RR1=4, RR2=4, ShiftCount=2, AluOp=1111, WE=1 with WR=5.
// 4. opcode 0x23 (lw) and funct 0x18 (mult) -> done=1, illegal=1, WE=0, retired unchanged.
// 5. add $0,$1,$2 with PROTECT_R0=1 -> done=1, WE=0, illegal=0, retired+1.
//    Repeat with PROTECT_R0=0 -> WE=1, WR=0.
// 6. Back-to-back: instr_valid held high with three instructions, EXEC_CYCLES=3.
//    - each is accepted only when instr_ready=1, every 6 cycles.
//    - exactly three WE pulses; retired=3.

Source files
------------

// File: rtl/rtype_issue_ctrl.sv
// Issue controller for one MIPS R-type instruction at a time: sequences register-file reads,
// ALU execution and write-back through IDLE -> READ -> EXEC -> WRITE.
module rtype_issue_ctrl #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter bit          PROTECT_R0  = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [4:0]  RR1,
  output logic [4:0]  RR2,
  output logic [4:0]  WR,
  output logic        WE,
  output logic [3:0]  AluOp,
  output logic [4:0]  ShiftCount,
  output logic        WbSel,
  output logic        done,
  output logic        illegal,
  output logic [15:0] retired
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        legal_q;
  logic [4:0]  rr1_q, rr2_q, wr_q, sc_q;
  logic [3:0]  op_q;
  logic        wbsel_q;
  logic [15:0] retired_q;

  logic        accept;
  logic        dec_legal, dec_shift;
  logic [3:0]  dec_op;

  assign accept = (state_q == IDLE) && instr_valid;

  always_comb begin
    dec_legal = (instr[31:26] == 6'h00);
    dec_shift = 1'b0;
    dec_op    = 4'b0000;
    case (instr[5:0])
      6'h20: dec_op = 4'b0010;
      6'h22: dec_op = 4'b0110;
      6'h24: dec_op = 4'b0000;
      6'h25: dec_op = 4'b0001;
      6'h27: dec_op = 4'b1100;
      6'h2A: dec_op = 4'b0111;
      6'h00: begin dec_op = 4'b1110; dec_shift = 1'b1; end
      6'h02: begin dec_op = 4'b1101; dec_shift = 1'b1; end
      6'h03: begin dec_op = 4'b1111; dec_shift = 1'b1; end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_op    = 4'b0000;
      dec_shift = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (instr_valid) state_d = READ;
      READ:  begin
        state_d = EXEC;
        cnt_d   = EXEC_LOAD;
      end
      EXEC:  begin
        if (cnt_q == 4'd0) state_d = WRITE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath outputs load at accept so they are valid throughout READ and hold afterwards.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      legal_q <= 1'b0;
      rr1_q   <= 5'd0;
      rr2_q   <= 5'd0;
      wr_q    <= 5'd0;
      sc_q    <= 5'd0;
      op_q    <= 4'd0;
      wbsel_q <= 1'b0;
    end else if (accept) begin
      legal_q <= dec_legal;
      rr1_q   <= dec_shift ? instr[20:16] : instr[25:21];
      rr2_q   <= instr[20:16];
      wr_q    <= instr[15:11];
      sc_q    <= dec_shift ? instr[10:6] : 5'd0;
      op_q    <= dec_op;
      wbsel_q <= 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      retired_q <= 16'd0;
    end else if (done && legal_q) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign done        = (state_q == WRITE);
  assign illegal     = done && !legal_q;
  assign WE          = done && legal_q && !(PROTECT_R0 && (wr_q == 5'd0));
  assign RR1         = rr1_q;
  assign RR2         = rr2_q;
  assign WR          = wr_q;
  assign AluOp       = op_q;
  assign ShiftCount  = sc_q;
  assign WbSel       = wbsel_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_rtype_issue_ctrl.sv
// Scoreboard bench for rtype_issue_ctrl: two instances (EXEC_CYCLES=1/PROTECT_R0=1 and
// EXEC_CYCLES=3/PROTECT_R0=0) driven with directed and random instructions.
module tb_rtype_issue_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] instr_s [2];
  logic        valid_s [2];
  logic        ready_s [2];
  logic        we_s    [2];
  logic        wbsel_s [2];
  logic        done_s  [2];
  logic        ill_s   [2];
  logic [4:0]  rr1_s   [2];
  logic [4:0]  rr2_s   [2];
  logic [4:0]  wr_s    [2];
  logic [4:0]  sc_s    [2];
  logic [3:0]  op_s    [2];
  logic [15:0] ret_s   [2];

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rtype_issue_ctrl #(
      .EXEC_CYCLES((g == 0) ? 1 : 3),
      .PROTECT_R0 ((g == 0) ? 1'b1 : 1'b0)
    ) u_dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .instr      (instr_s[g]),
      .instr_valid(valid_s[g]),
      .instr_ready(ready_s[g]),
      .RR1        (rr1_s[g]),
      .RR2        (rr2_s[g]),
      .WR         (wr_s[g]),
      .WE         (we_s[g]),
      .AluOp      (op_s[g]),
      .ShiftCount (sc_s[g]),
      .WbSel      (wbsel_s[g]),
      .done       (done_s[g]),
      .illegal    (ill_s[g]),
      .retired    (ret_s[g])
    );
  end

  typedef struct {
    logic        legal;
    logic        we;
    logic [3:0]  op;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  sc;
    logic [4:0]  wr;
    logic [15:0] ret;
  } exp_t;

  exp_t        sb [2][$];
  exp_t        cur [2];
  bit          busy [2];
  bit          post [2];
  int          cyc [2];
  logic [15:0] model_ret [2];
  int          cyc_g = 0;
  int          total = 0;
  int          bad = 0;
  logic [5:0]  fn_tab [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};

  function automatic int exec_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h at cycle %0d", name, i, act, exp, cyc_g);
    end
  endtask

  // Reference: MIPS R-type semantics as a lookup of funct to ALU code.
  function automatic exp_t model(input int i, input logic [31:0] w);
    exp_t e;
    bit   shift = 0;
    e.legal = (w[31:26] == 6'h00);
    e.op    = 4'b0000;
    case (w[5:0])
      6'h20: e.op = 4'b0010;
      6'h22: e.op = 4'b0110;
      6'h24: e.op = 4'b0000;
      6'h25: e.op = 4'b0001;
      6'h27: e.op = 4'b1100;
      6'h2A: e.op = 4'b0111;
      6'h00: begin e.op = 4'b1110; shift = 1; end
      6'h02: begin e.op = 4'b1101; shift = 1; end
      6'h03: begin e.op = 4'b1111; shift = 1; end
      default: e.legal = 0;
    endcase
    if (!e.legal) e.op = 4'b0000;
    e.rr1 = shift ? w[20:16] : w[25:21];
    e.rr2 = w[20:16];
    e.sc  = shift ? w[10:6] : 5'd0;
    e.wr  = w[15:11];
    e.we  = e.legal && !((i == 0) && (w[15:11] == 5'd0));
    e.ret = model_ret[i];
    return e;
  endfunction

  always @(posedge Clk) cyc_g <= cyc_g + 1;

  always @(negedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      if (Rst) begin
        busy[i] = 0;
        post[i] = 0;
      end else begin
        if (post[i]) begin
          chk("ready_after_done", i, ready_s[i], 1);
          post[i] = 0;
        end
        if (busy[i]) begin
          cyc[i]++;
          chk("busy_ready", i, ready_s[i], 0);
          if (cyc[i] == 1) begin
            chk("read_wbsel", i, wbsel_s[i], 1);
            chk("read_aluop", i, op_s[i], cur[i].op);
            if (cur[i].legal) begin
              chk("read_rr1", i, rr1_s[i], cur[i].rr1);
              chk("read_rr2", i, rr2_s[i], cur[i].rr2);
              chk("read_shamt", i, sc_s[i], cur[i].sc);
            end
          end
          if (done_s[i]) begin
            chk("done_latency", i, cyc[i], exec_of(i) + 2);
            chk("write_we", i, we_s[i], cur[i].we);
            chk("write_illegal", i, ill_s[i], !cur[i].legal);
            chk("write_aluop", i, op_s[i], cur[i].op);
            chk("write_retired", i, ret_s[i], cur[i].ret);
            if (cur[i].we) chk("write_wr", i, wr_s[i], cur[i].wr);
            busy[i] = 0;
            post[i] = 1;
          end else if (cyc[i] > exec_of(i) + 4) begin
            chk("done_timeout", i, 0, 1);
            busy[i] = 0;
          end
        end else if (done_s[i] || we_s[i]) begin
          chk("stray_pulse", i, {done_s[i], we_s[i]}, 0);
        end
        if (we_s[i] && !done_s[i]) chk("we_without_done", i, 1, 0);
        if (!busy[i] && ready_s[i] && valid_s[i]) begin
          if (sb[i].size() == 0) begin
            chk("unexpected_accept", i, 1, 0);
          end else begin
            cur[i]  = sb[i].pop_front();
            busy[i] = 1;
            cyc[i]  = 0;
          end
        end
      end
    end
  end

  // Presents w on dut i, returns at posedge+1 of the accepting edge with valid left high.
  task automatic issue(input int i, input logic [31:0] w, output int acc);
    exp_t e;
    int   n = 0;
    e = model(i, w);
    sb[i].push_back(e);
    if (e.legal) model_ret[i] = model_ret[i] + 16'd1;
    instr_s[i] = w;
    valid_s[i] = 1'b1;
    @(negedge Clk);
    while (!ready_s[i] && n < 60) begin
      @(negedge Clk);
      n++;
    end
    if (!ready_s[i]) chk("accept_timeout", i, 0, 1);
    acc = cyc_g;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rd;
    op = ($urandom_range(0, 9) == 0) ? 6'h23 : 6'h00;
    fn = ($urandom_range(0, 9) == 0) ? 6'h18 : fn_tab[$urandom_range(0, 8)];
    rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    return {op, 5'($urandom), 5'($urandom), rd, 5'($urandom), fn};
  endfunction

  task automatic drain();
    int n = 0;
    while ((busy[0] || busy[1] || post[0] || post[1]) && n < 60) begin
      @(negedge Clk);
      n++;
    end
    chk("drain", 0, {busy[0], busy[1]}, 0);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int a0, a1, a2;
    Rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      instr_s[i] = 32'h0;
      valid_s[i] = 1'b0;
      model_ret[i] = 16'd0;
    end
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", i, ready_s[i], 1);
      chk("rst_pulses", i, {we_s[i], done_s[i], ill_s[i]}, 0);
      chk("rst_datapath", i, {rr1_s[i], rr2_s[i], wr_s[i], sc_s[i], op_s[i], wbsel_s[i]}, 0);
      chk("rst_retired", i, ret_s[i], 0);
    end
    @(posedge Clk);
    #1;

    // Abort an add in EXEC with a reset pulse.
    issue(0, 32'h00221820, a0);
    valid_s[0] = 1'b0;
    @(posedge Clk);
    #1 Rst = 1'b1;
    @(posedge Clk);
    #1 Rst = 1'b0;
    model_ret[0] = 16'd0;
    @(negedge Clk);
    chk("abort_ready", 0, ready_s[0], 1);
    chk("abort_retired", 0, ret_s[0], 0);
    @(posedge Clk);
    #1;

    issue(0, 32'h00221820, a0);          // add $3,$1,$2
    valid_s[0] = 1'b0;
    drain();
    chk("add_retired", 0, ret_s[0], 1);
    issue(0, 32'h00042883, a0);          // sra $5,$4,2
    valid_s[0] = 1'b0;
    issue(0, 32'h8C221820, a0);          // lw opcode
    valid_s[0] = 1'b0;
    issue(0, 32'h00221818, a0);          // mult funct
    valid_s[0] = 1'b0;
    issue(0, 32'h00220020, a0);          // add $0,$1,$2, protected
    valid_s[0] = 1'b0;
    issue(1, 32'h00220020, a0);          // add $0,$1,$2, unprotected
    valid_s[1] = 1'b0;
    drain();
    chk("directed_retired", 0, ret_s[0], 3);

    // Back-to-back with valid held on the EXEC_CYCLES=3 instance.
    issue(1, 32'h00221820, a0);
    issue(1, 32'h00642022, a1);
    issue(1, 32'h00A62824, a2);
    valid_s[1] = 1'b0;
    chk("b2b_gap1", 1, a1 - a0, 6);
    chk("b2b_gap2", 1, a2 - a1, 6);
    drain();
    chk("b2b_retired", 1, ret_s[1], 4);

    for (int b = 0; b < 30; b++) begin
      int i = int'($urandom_range(0, 1));
      int len = int'($urandom_range(1, 4));
      for (int k = 0; k < len; k++) issue(i, rand_instr(), a0);
      valid_s[i] = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge Clk);
      #1;
    end
    drain();
    for (int i = 0; i < 2; i++) chk("final_retired", i, ret_s[i], model_ret[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
